// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO push-side arbiter: the lock FSM encoding,
// the round-robin pointer advance, and the default burst length.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } fsm_e;

  localparam int DEF_MAX_BURST = 4;
  localparam int BURST_CNT_W   = 4;

  // Advance a round-robin index by one, wrapping nreq-1 back to 0.
  function automatic int rr_next(input int idx, input int nreq);
    return (idx >= nreq - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder. Returns the first set bit
// of req_i found when scanning base_i, base_i+1, ... modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the base index around the ring; the first hit wins.
  always_comb begin
    int c;
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(base_i) + k;
      if (c >= N) c = c - N;
      if (!found_o && req_i[c]) begin
        found_o = 1'b1;
        idx_o   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin write-port arbiter in front of a single FIFO.
// Converts per-requester valid/ready into single-cycle pushes and never pushes
// while fifo_full is high. Define FIFO_ARB_BURST_EN to let a winner keep the
// port for up to MAX_BURST consecutive beats.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic                     gnt_valid,
  output logic [$clog2(NREQ)-1:0]  gnt_id
);

  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_cfg_err
    $error("fifo_push_arbiter: NREQ must be 2..8 and MAX_BURST 1..15");
  end

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] base, pick_idx, win_id;
  logic           pick_found, win_found, accept;

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req_i   (req_valid),
    .base_i  (base),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef FIFO_ARB_BURST_EN
  fsm_e                   fsm_q, fsm_d;
  logic [IDW-1:0]         lock_id_q, lock_id_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   lock_hold, lock_rel;
  logic [IDW-1:0]         lock_nxt;

  assign lock_hold = (fsm_q == LOCK) &&  req_valid[lock_id_q];
  assign lock_rel  = (fsm_q == LOCK) && !req_valid[lock_id_q];
  assign lock_nxt  = IDW'(rr_next(int'(lock_id_q), NREQ));

  // A dropped lock releases in the same cycle; arbitration restarts past the
  // old owner so the port never idles for a bubble.
  assign base      = lock_rel ? lock_nxt : rr_ptr_q;
  assign win_found = lock_hold | pick_found;
  assign win_id    = lock_hold ? lock_id_q : pick_idx;
`else
  assign base      = rr_ptr_q;
  assign win_found = pick_found;
  assign win_id    = pick_idx;
`endif

  // A beat transfers only with a winner, FIFO space, and outside reset.
  assign accept    = !rst && !fifo_full && win_found;
  assign fifo_push = accept;
  assign gnt_valid = accept;

  // Drive the handshake and data mux; everything reads zero when no push.
  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    gnt_id       = '0;
    if (accept) begin
      req_ready[win_id] = 1'b1;
      fifo_data_in      = req_data[int'(win_id)*WIDTH +: WIDTH];
      gnt_id            = win_id;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  // Next-state: full freezes everything; otherwise handle release, then the beat.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    fsm_d       = fsm_q;
    lock_id_d   = lock_id_q;
    burst_cnt_d = burst_cnt_q;
    if (!fifo_full) begin
      if (lock_rel) begin
        rr_ptr_d    = lock_nxt;
        fsm_d       = IDLE;
        burst_cnt_d = '0;
      end
      if (accept) begin
        if (lock_hold) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q + 1'b1 == BURST_CNT_W'(MAX_BURST)) begin
            fsm_d       = IDLE;
            rr_ptr_d    = lock_nxt;
            burst_cnt_d = '0;
          end
        end else if (MAX_BURST > 1) begin
          fsm_d       = LOCK;
          lock_id_d   = win_id;
          burst_cnt_d = BURST_CNT_W'(1);
        end else begin
          rr_ptr_d = IDW'(rr_next(int'(win_id), NREQ));
        end
      end
    end
  end

  // State registers; reset drops any lock and restarts priority at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      fsm_q       <= IDLE;
      lock_id_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      fsm_q       <= fsm_d;
      lock_id_q   <= lock_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  // Next-state: priority moves just past each accepted winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = IDW'(rr_next(int'(win_id), NREQ));
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
// Inputs change on the falling edge; outputs are checked 2 time units later.
module tb_fifo_push_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full = 1'b0;
  logic                  fifo_push;
  logic [WIDTH-1:0]      fifo_data_in;
  logic                  gnt_valid;
  logic [IDW-1:0]        gnt_id;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_push_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_push    (fifo_push),
    .fifo_data_in (fifo_data_in),
    .gnt_valid    (gnt_valid),
    .gnt_id       (gnt_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [NREQ-1:0] v, input logic full);
    @(negedge clk);
    req_valid = v;
    fifo_full = full;
    #2;
  endtask

  task automatic expect_beat(input string tag, input int id);
    logic [NREQ-1:0]  rdy;
    logic [WIDTH-1:0] dat;
    rdy = '0;
    rdy[id] = 1'b1;
    dat = 8'hA0 + 8'(id);
    chk({tag, ".push"},  32'(fifo_push),    32'd1);
    chk({tag, ".gvld"},  32'(gnt_valid),    32'd1);
    chk({tag, ".gid"},   32'(gnt_id),       32'(id));
    chk({tag, ".ready"}, 32'(req_ready),    32'(rdy));
    chk({tag, ".data"},  32'(fifo_data_in), 32'(dat));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".push"},  32'(fifo_push),    32'd0);
    chk({tag, ".gvld"},  32'(gnt_valid),    32'd0);
    chk({tag, ".gid"},   32'(gnt_id),       32'd0);
    chk({tag, ".ready"}, 32'(req_ready),    32'd0);
    chk({tag, ".data"},  32'(fifo_data_in), 32'd0);
  endtask

  initial begin
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Held in reset with everyone requesting: all outputs forced low.
    cyc(4'b1111, 1'b0);
    expect_idle("rst_hold");

    // Release reset while inputs are already valid; first grant is index 0.
    @(negedge clk);
    rst = 1'b0;
    #2;

`ifdef FIFO_ARB_BURST_EN
    // Reqs 0 and 1 always valid: 0,0,0,0,1,1,1,1,0.
    req_valid = 4'b0011;
    #1;
    expect_beat("burst0", 0);
    begin
      int seq[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 8; i++) begin
        cyc(4'b0011, 1'b0);
        expect_beat($sformatf("burst%0d", i + 1), seq[i]);
      end
    end
    // Lock on 0 (count 1). Full holds the lock and count.
    cyc(4'b0011, 1'b1);
    expect_idle("lock_full");
    cyc(4'b1011, 1'b0);
    expect_beat("lock_after_full", 0);
    // Req 0 drops after 2 beats: req 3 wins in that same cycle.
    cyc(4'b1000, 1'b0);
    expect_beat("lock_release", 3);
    cyc(4'b1001, 1'b0);
    expect_beat("lock3_hold", 3);
    // Asynchronous reset while req 3 holds the lock.
    @(negedge clk);
    req_valid = 4'b1001;
    #2;
    rst = 1'b1;
    #1;
    expect_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #2;
    expect_beat("post_rst", 0);
`else
    req_valid = 4'b1111;
    #1;
    expect_beat("rr0", 0);
    for (int i = 1; i < 8; i++) begin
      cyc(4'b1111, 1'b0);
      expect_beat($sformatf("rr%0d", i), i % 4);
    end
    // rr_ptr is 0: lone req 2 wins, then again with rr_ptr=3.
    cyc(4'b0100, 1'b0);
    expect_beat("solo2_a", 2);
    cyc(4'b0100, 1'b0);
    expect_beat("solo2_b", 2);
    // rr_ptr must now be 3.
    cyc(4'b1111, 1'b0);
    expect_beat("ptr3", 3);
    // Full for 3 cycles: no push, then req 1 goes through.
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0010, 1'b1);
      expect_idle($sformatf("full%0d", i));
    end
    cyc(4'b0010, 1'b0);
    expect_beat("full_drop", 1);
    // No requests: idle, pointer holds at 2.
    cyc(4'b0000, 1'b0);
    expect_idle("none");
    cyc(4'b1111, 1'b0);
    expect_beat("ptr_hold", 2);
    // rr_ptr is now 3; async reset returns priority to index 0.
    @(negedge clk);
    req_valid = 4'b1010;
    #2;
    rst = 1'b1;
    #1;
    expect_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #2;
    expect_beat("post_rst", 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin write-port arbiter that shares one `circular_pointer_fifo` instance between NREQ producers. It sits directly in front of the FIFO's push/data_in/full port, converts per-requester valid/ready handshakes into single-cycle FIFO pushes, and never pushes while the FIFO reports full. Optional burst locking lets one producer keep the port for up to MAX_BURST consecutive beats.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 8: data width; must match the FIFO WIDTH.
- MAX_BURST, 4: maximum beats per locked grant, 1..15; used only with FIFO_ARB_BURST_EN.
- IDW (localparam), $clog2(NREQ): grant-index width.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester valid.
- req_data  in  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  per-requester ready; one-hot or zero.
- fifo_full  in  1  FIFO full flag.
- fifo_push  out  1  FIFO push strobe.
- fifo_data_in  out  WIDTH  FIFO write data.
- gnt_valid  out  1  a grant is active this cycle (equals fifo_push).
- gnt_id  out  IDW  index of the granted requester; 0 when gnt_valid is 0.

## Operation
- State: rr_ptr (IDW bits, highest-priority index), fsm {IDLE, LOCK}, lock_id (IDW), burst_cnt (4 bits).
- IDLE: winner is the first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, ... modulo NREQ. If fifo_full=0 and a winner exists, then req_ready[winner]=1, fifo_push=1, and fifo_data_in=req_data[winner].
- On an accepted beat without FIFO_ARB_BURST_EN: rr_ptr <= winner+1, wrapping NREQ-1 to 0.
- fifo_full=1: all req_ready=0 and fifo_push=0. rr_ptr, fsm and burst_cnt hold.
- No valid requester: outputs idle and state holds.
- fifo_data_in is 0 when fifo_push=0.
- Handshake rule: a beat transfers only when req_valid[i] and req_ready[i] are both 1. Requesters must hold valid and data stable until accepted. The arbiter never pushes without a matching handshake.

## Timing
- Zero-latency, combinational path from req_valid/fifo_full to req_ready/fifo_push. The data is written into the FIFO at the same rising edge as the handshake.
- Sustained throughput: 1 beat/cycle while the FIFO is not full.
- Reset values (asynchronous): rr_ptr=0, fsm=IDLE, lock_id=0, burst_cnt=0.
- While rst=1, all outputs are forced to 0: req_ready=0, fifo_push=0, gnt_valid=0, gnt_id=0, fifo_data_in=0.
- Reset mid-burst discards the lock immediately. The first grant after reset goes to the lowest valid index.
- Simultaneous FIFO pop in the same cycle has no effect on the decision; only fifo_full is used.

## Configuration
FIFO_ARB_BURST_EN:
- Defined:
  - An accepted beat in IDLE with MAX_BURST>1 moves fsm to LOCK, with lock_id=winner and burst_cnt=1.
  - In LOCK, only lock_id may be granted. Each accepted beat increments burst_cnt.
  - When a beat makes burst_cnt==MAX_BURST, the next state is IDLE and rr_ptr <= lock_id+1.
  - If req_valid[lock_id]=0 in LOCK, the lock releases combinationally. Normal IDLE arbitration runs in that same cycle, so there is no bubble. rr_ptr <= lock_id+1 and fsm <= IDLE, or LOCK on the new winner if it is accepted.
  - fifo_full in LOCK holds the lock and burst_cnt.
  - With MAX_BURST=1, behaviour is identical to the undefined case.
- Undefined: fsm, lock_id and burst_cnt are not generated; pure per-beat round-robin.

## Structure
- Shared package `fifo_arb_pkg`: the fsm enum typedef (IDLE, LOCK), the rr_ptr increment/wrap function, and the default MAX_BURST constant.
- One natural sub-module, `rr_pick`: a combinational rotate-priority encoder with inputs req vector and base index, outputs found and index. It is reusable by a future pop-side scheduler.

## Test plan
- Reset, then NREQ=4 with all valid held high and the FIFO never full, burst undefined → gnt_id sequence 0,1,2,3,0,…, one push per cycle.
- Only req 2 valid, with rr_ptr=3 → grant 2. A single push with fifo_data_in=req_data[2]. rr_ptr becomes 3.
- fifo_full=1 for 3 cycles while req 1 is valid → no push and req_ready=0. When full drops, req 1 is pushed on the next cycle.
- FIFO_ARB_BURST_EN, MAX_BURST=4, reqs 0 and 1 always valid → pattern 0,0,0,0,1,1,1,1,0…
- FIFO_ARB_BURST_EN: req 0 drops valid after 2 beats while req 3 is valid → req 3 is granted in the same cycle, with no idle cycle.
- Assert rst asynchronously mid-lock with req 3 locked → outputs go to 0 immediately. After release, the first grant is to the lowest valid index.
